// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port among NREQ writeback sources.
// Round-robin grant with a valid/ready handshake per source, followed by a
// registered write stage driving RegWrite/WriteRg/WriteData. Writes to $0
// complete their handshake but never raise RegWrite.
// Optional feature: define RF_WB_BYPASS_EN to add the write-stage bypass
// compare (byp_hit/byp_data); without it those outputs are tied to zero.
module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rg,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 wb_hold,
    output logic                 RegWrite,
    output logic [AW-1:0]        WriteRg,
    output logic [DW-1:0]        WriteData,
    input  logic [AW-1:0]        byp_rg1,
    input  logic [AW-1:0]        byp_rg2,
    output logic                 byp_hit1,
    output logic                 byp_hit2,
    output logic [DW-1:0]        byp_data1,
    output logic [DW-1:0]        byp_data2
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] rotValid;
    logic [PW:0]     winSum;
    logic [PW-1:0]   winner;
    logic            found;
    logic            accept;
    logic [AW-1:0]   winRg;
    logic [DW-1:0]   winData;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, and map
    // it back to an absolute requester index modulo NREQ.
    always_comb begin
        rotValid = NREQ'({req_valid, req_valid} >> ptr);
        winSum   = '0;
        found    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotValid[k]) begin
                found  = 1'b1;
                winSum = {1'b0, ptr} + k[PW:0];
            end
        end
        if (winSum >= NREQ_W) begin
            winSum = winSum - NREQ_W;
        end
        winner = winSum[PW-1:0];
    end

    // One-hot ready for the winner; suppressed during hold and reset.
    always_comb begin
        req_ready = '0;
        if (found && !wb_hold && !Reset) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign accept = |req_ready;

    // Select the winning requester's destination and data.
    always_comb begin
        winRg   = '0;
        winData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == i[PW-1:0]) begin
                winRg   = req_rg[i*AW +: AW];
                winData = req_data[i*DW +: DW];
            end
        end
    end

    // Write stage and round-robin pointer; address/data hold when idle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr       <= '0;
            RegWrite  <= 1'b0;
            WriteRg   <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (accept) begin
                WriteRg   <= winRg;
                WriteData <= winData;
                RegWrite  <= (winRg != '0);
                ptr       <= (winner == LAST) ? '0 : winner + 1'b1;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Forward the registered write during the cycle before the regfile has it.
    always_comb begin
        byp_hit1  = RegWrite && (WriteRg == byp_rg1) && (byp_rg1 != '0);
        byp_hit2  = RegWrite && (WriteRg == byp_rg2) && (byp_rg2 != '0);
        byp_data1 = byp_hit1 ? WriteData : '0;
        byp_data2 = byp_hit2 ? WriteData : '0;
    end
`else
    // Bypass disabled: compare addresses are ignored.
    logic unusedBypRg;
    assign unusedBypRg = ^{byp_rg1, byp_rg2};
    assign byp_hit1    = 1'b0;
    assign byp_hit2    = 1'b0;
    assign byp_data1   = '0;
    assign byp_data2   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter (NREQ=4): directed vector table, hand-written
// corner sequences and random traffic, all against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic                Clock = 1'b0;
    logic                Reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_rg;
    logic [NREQ*DW-1:0]  req_data;
    logic                wb_hold;
    logic                RegWrite;
    logic [AW-1:0]       WriteRg;
    logic [DW-1:0]       WriteData;
    logic [AW-1:0]       byp_rg1;
    logic [AW-1:0]       byp_rg2;
    logic                byp_hit1;
    logic                byp_hit2;
    logic [DW-1:0]       byp_data1;
    logic [DW-1:0]       byp_data2;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rg(req_rg), .req_data(req_data), .wb_hold(wb_hold),
        .RegWrite(RegWrite), .WriteRg(WriteRg), .WriteData(WriteData),
        .byp_rg1(byp_rg1), .byp_rg2(byp_rg2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    always #5 Clock = ~Clock;

    // Register file fed by the DUT write port.
    logic [DW-1:0] rf [32];
    always @(posedge Clock) begin
        if (RegWrite) rf[WriteRg] <= WriteData;
    end

    typedef struct {
        bit         rst;
        bit         hold;
        logic [3:0] valid;
        logic [3:0] expReady;
        bit         expRW;
        logic [4:0] expRg;
    } vec_t;

    vec_t tbl [14];
    vec_t noVec;

    int nChecks = 0;
    int nPass   = 0;

    // Stimulus state
    int            rgArr   [NREQ];
    logic [DW-1:0] dataArr [NREQ];
    logic [NREQ-1:0] vldIn;
    bit            holdIn;
    bit            rstIn;
    logic [AW-1:0] byp1In;
    logic [AW-1:0] byp2In;

    // Reference model state
    int              mPtr;
    bit              mRW;
    logic [AW-1:0]   mRg;
    logic [DW-1:0]   mData;
    logic [DW-1:0]   mrf [32];
    int              mWin;
    logic [NREQ-1:0] mReadyExp;
    int              lastAccepted;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic modelArb();
        mReadyExp = '0;
        mWin = -1;
        if (!rstIn && !holdIn) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (mPtr + k) % NREQ;
                if (mWin < 0 && vldIn[i]) mWin = i;
            end
        end
        if (mWin >= 0) mReadyExp[mWin] = 1'b1;
    endtask

    task automatic runCycle(input bit useVec, input vec_t v);
        logic expHit1, expHit2;
        Reset     = rstIn;
        wb_hold   = holdIn;
        req_valid = vldIn;
        for (int i = 0; i < NREQ; i++) begin
            req_rg[i*AW +: AW]   = rgArr[i][AW-1:0];
            req_data[i*DW +: DW] = dataArr[i];
        end
        byp_rg1 = byp1In;
        byp_rg2 = byp2In;
        @(negedge Clock);
        modelArb();
        check("req_ready", req_ready, mReadyExp);
        check("RegWrite", RegWrite, mRW);
        check("WriteRg", WriteRg, mRg);
        check("WriteData", WriteData, mData);
        expHit1 = BYP_EN && mRW && (mRg == byp1In) && (byp1In != 0);
        expHit2 = BYP_EN && mRW && (mRg == byp2In) && (byp2In != 0);
        check("byp_hit1", byp_hit1, expHit1);
        check("byp_hit2", byp_hit2, expHit2);
        check("byp_data1", byp_data1, expHit1 ? mData : '0);
        check("byp_data2", byp_data2, expHit2 ? mData : '0);
        if (useVec) begin
            check("tbl_ready", req_ready, v.expReady);
            check("tbl_RegWrite", RegWrite, v.expRW);
            check("tbl_WriteRg", WriteRg, v.expRg);
        end
        @(posedge Clock);
        if (mRW) mrf[mRg] = mData;
        lastAccepted = -1;
        if (rstIn) begin
            mPtr = 0; mRW = 1'b0; mRg = '0; mData = '0;
        end else if (mWin >= 0) begin
            mRg   = rgArr[mWin][AW-1:0];
            mData = dataArr[mWin];
            mRW   = (rgArr[mWin] != 0);
            mPtr  = (mWin + 1) % NREQ;
            lastAccepted = mWin;
        end else begin
            mRW = 1'b0;
        end
        #1;
    endtask

    initial begin
        noVec = '{1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 5'd0};
        for (int i = 0; i < 32; i++) begin
            rf[i]  = '0;
            mrf[i] = '0;
        end
        rgArr[0] = 3; dataArr[0] = 32'hAAAA0000;
        rgArr[1] = 4; dataArr[1] = 32'h5555FFFF;
        rgArr[2] = 0; dataArr[2] = 32'hDEADBEEF;
        rgArr[3] = 9; dataArr[3] = 32'h0000BEEF;
        vldIn = '1; holdIn = 1'b0; rstIn = 1'b1; byp1In = '0; byp2In = '0;

        // Initial reset edge establishes a known state before checking.
        Reset = 1'b1; wb_hold = 1'b0; req_valid = '1; req_rg = '0; req_data = '0;
        byp_rg1 = '0; byp_rg2 = '0;
        @(posedge Clock);
        #1;
        mPtr = 0; mRW = 1'b0; mRg = '0; mData = '0;

        //          rst   hold  valid    expReady expRW expRg
        tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 5'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'b0011, 4'b0001, 1'b0, 5'd0};
        tbl[3]  = '{1'b0, 1'b0, 4'b0011, 4'b0010, 1'b1, 5'd3};
        tbl[4]  = '{1'b0, 1'b0, 4'b0011, 4'b0001, 1'b1, 5'd4};
        tbl[5]  = '{1'b0, 1'b0, 4'b0011, 4'b0010, 1'b1, 5'd3};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd4};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd4};
        tbl[8]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 5'd4};
        tbl[9]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 5'd9};
        tbl[10] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 5'd3};
        tbl[11] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 5'd4};
        tbl[12] = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b0, 5'd4};
        tbl[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};

        for (int t = 0; t < 14; t++) begin
            rstIn  = tbl[t].rst;
            holdIn = tbl[t].hold;
            vldIn  = tbl[t].valid;
            runCycle(1'b1, tbl[t]);
        end
        check("rf_r3", rf[3], 32'hAAAA0000);
        check("rf_r4", rf[4], 32'h5555FFFF);

        // $0 request: handshake completes, no register write.
        rgArr[0] = 0; dataArr[0] = 32'hDEADBEEF;
        vldIn = 4'b0001;
        runCycle(1'b1, '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 5'd0});
        vldIn = 4'b0000;
        runCycle(1'b1, '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0});
        runCycle(1'b0, noVec);
        check("rf_r0", rf[0], 32'h0);

        // Hold raised on the accept edge: registered write still issues.
        rgArr[1] = 7; dataArr[1] = 32'h12345678;
        vldIn = 4'b0010;
        runCycle(1'b1, '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 5'd0});
        holdIn = 1'b1; vldIn = 4'b1111;
        runCycle(1'b1, '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 5'd7});
        runCycle(1'b1, '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 5'd7});
        runCycle(1'b1, '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 5'd7});
        holdIn = 1'b0;
        runCycle(1'b1, '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b0, 5'd7});
        vldIn = 4'b0000;
        runCycle(1'b0, noVec);
        check("rf_r7", rf[7], 32'h12345678);

        // Bypass on the registered-but-uncommitted write.
        vldIn = 4'b1000; byp1In = 5'd9; byp2In = 5'd0;
        runCycle(1'b0, noVec);
        check("byp_seq_hit1", byp_hit1, BYP_EN);
        check("byp_seq_data1", byp_data1, BYP_EN ? 32'h0000BEEF : 32'h0);
        check("byp_seq_hit2", byp_hit2, 1'b0);
        vldIn = 4'b0000;
        runCycle(1'b0, noVec);

        // Random traffic with cancellations, holds and occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (vldIn[i] && i != lastAccepted) begin
                    if ($urandom_range(7) == 0) vldIn[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    vldIn[i]   = 1'b1;
                    rgArr[i]   = int'($urandom_range(31));
                    dataArr[i] = $urandom;
                end else begin
                    vldIn[i] = 1'b0;
                end
            end
            holdIn = ($urandom_range(5) == 0);
            rstIn  = ($urandom_range(59) == 0);
            byp1In = ($urandom_range(1) == 1) ? mRg : AW'($urandom_range(31));
            byp2In = AW'($urandom_range(31));
            runCycle(1'b0, noVec);
        end
        rstIn = 1'b0; holdIn = 1'b0; vldIn = '0;
        runCycle(1'b0, noVec);
        runCycle(1'b0, noVec);
        for (int r = 1; r < 32; r++) begin
            check("rf_final", rf[r], mrf[r]);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
